rs_dispatch: RTL and testbench

//  Reservation-station holder/selector feeding the execution unit. Accepts issued ops, captures

---
 rtl/rs_dispatch.sv | 216 +++++++++++++++++++++
 tb/tb_rs_dispatch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dispatch.sv
// Reservation station for one functional-unit class: holds issued ops, wakes
// up operands from the result broadcast bus, and dispatches the oldest ready op
// into a registered exec port that holds stable under back-pressure.
module rs_dispatch #(
  parameter int unsigned NUM_ENT = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned ROB_W   = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [3:0]        iss_func,
  input  logic [TAG_W-1:0]  iss_rd,
  input  logic [ROB_W-1:0]  iss_rob,
  input  logic              iss_s1_rdy,
  input  logic [DATA_W-1:0] iss_s1_val,
  input  logic [TAG_W-1:0]  iss_s1_tag,
  input  logic              iss_s2_rdy,
  input  logic [DATA_W-1:0] iss_s2_val,
  input  logic [TAG_W-1:0]  iss_s2_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              exec_b,
  input  logic              exec_ready,
  output logic [2:0]        rs_index,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [3:0]        func,
  output logic [ROB_W-1:0]  rob_ind,
  output logic [TAG_W-1:0]  rd
);

  // Entry storage
  logic [NUM_ENT-1:0] valid;
  logic [NUM_ENT-1:0] sent;
  logic [NUM_ENT-1:0] s1_rdy;
  logic [NUM_ENT-1:0] s2_rdy;
  logic [DATA_W-1:0]  s1_val [NUM_ENT];
  logic [DATA_W-1:0]  s2_val [NUM_ENT];
  logic [TAG_W-1:0]   s1_tag [NUM_ENT];
  logic [TAG_W-1:0]   s2_tag [NUM_ENT];
  logic [3:0]         e_func [NUM_ENT];
  logic [TAG_W-1:0]   e_rd   [NUM_ENT];
  logic [ROB_W-1:0]   e_rob  [NUM_ENT];
  // age[i][j] = 1 means entry i is older than entry j
  logic [NUM_ENT-1:0] age    [NUM_ENT];

  // Combinational control
  logic [NUM_ENT-1:0] alloc_oh;
  logic               alloc_hit;
  logic               alloc_en;
  logic [NUM_ENT-1:0] cand;
  logic [NUM_ENT-1:0] older;
  logic [NUM_ENT-1:0] sel_oh;
  logic               sel_hit;
  logic [2:0]         sel_idx;
  logic [DATA_W-1:0]  sel_s1;
  logic [DATA_W-1:0]  sel_s2;
  logic [3:0]         sel_func;
  logic [TAG_W-1:0]   sel_rd;
  logic [ROB_W-1:0]   sel_rob;
  logic [NUM_ENT-1:0] ret_oh;
  logic               load;
  logic               retire;
  logic               new_s1_rdy;
  logic               new_s2_rdy;
  logic [DATA_W-1:0]  new_s1_val;
  logic [DATA_W-1:0]  new_s2_val;

  assign iss_ready = ~&valid;
  assign alloc_en  = iss_valid && iss_ready;
  assign load      = !exec_b || exec_ready;
  assign retire    = exec_b && exec_ready;

  // Issue bypass: a source broadcast in the issue cycle is captured as ready
  always_comb begin
    new_s1_rdy = iss_s1_rdy;
    new_s1_val = iss_s1_val;
    new_s2_rdy = iss_s2_rdy;
    new_s2_val = iss_s2_val;
    if (!iss_s1_rdy && cdb_valid && (cdb_tag == iss_s1_tag)) begin
      new_s1_rdy = 1'b1;
      new_s1_val = cdb_data;
    end
    if (!iss_s2_rdy && cdb_valid && (cdb_tag == iss_s2_tag)) begin
      new_s2_rdy = 1'b1;
      new_s2_val = cdb_data;
    end
  end

  // Lowest-index free entry for allocation
  always_comb begin
    alloc_oh  = '0;
    alloc_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_ENT; i++) begin
      if (!valid[i] && !alloc_hit) begin
        alloc_hit   = 1'b1;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  // Oldest ready candidate: one with no older candidate in the age matrix
  always_comb begin
    cand  = valid & ~sent & s1_rdy & s2_rdy;
    older = '0;
    for (int unsigned i = 0; i < NUM_ENT; i++) begin
      for (int unsigned j = 0; j < NUM_ENT; j++) begin
        if (j != i && cand[j] && age[j][i]) older[i] = 1'b1;
      end
    end
    sel_oh  = cand & ~older;
    sel_hit = |cand;
  end

  // Mux selected entry fields and decode the retiring index
  always_comb begin
    sel_idx  = '0;
    sel_s1   = '0;
    sel_s2   = '0;
    sel_func = '0;
    sel_rd   = '0;
    sel_rob  = '0;
    ret_oh   = '0;
    for (int unsigned i = 0; i < NUM_ENT; i++) begin
      if (sel_oh[i]) begin
        sel_idx  = i[2:0];
        sel_s1   = s1_val[i];
        sel_s2   = s2_val[i];
        sel_func = e_func[i];
        sel_rd   = e_rd[i];
        sel_rob  = e_rob[i];
      end
      ret_oh[i] = (rs_index == i[2:0]);
    end
  end

  // Entry state, age matrix and exec output register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      sent     <= '0;
      s1_rdy   <= '0;
      s2_rdy   <= '0;
      for (int unsigned i = 0; i < NUM_ENT; i++) begin
        s1_val[i] <= '0;
        s2_val[i] <= '0;
        s1_tag[i] <= '0;
        s2_tag[i] <= '0;
        e_func[i] <= '0;
        e_rd[i]   <= '0;
        e_rob[i]  <= '0;
        age[i]    <= '0;
      end
      exec_b   <= 1'b0;
      rs_index <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      func     <= '0;
      rob_ind  <= '0;
      rd       <= '0;
    end else if (flush) begin
      valid  <= '0;
      sent   <= '0;
      exec_b <= 1'b0;
      for (int unsigned i = 0; i < NUM_ENT; i++) age[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENT; i++) begin
        if (retire && ret_oh[i]) valid[i] <= 1'b0;
        if (valid[i] && !s1_rdy[i] && cdb_valid && (s1_tag[i] == cdb_tag)) begin
          s1_rdy[i] <= 1'b1;
          s1_val[i] <= cdb_data;
        end
        if (valid[i] && !s2_rdy[i] && cdb_valid && (s2_tag[i] == cdb_tag)) begin
          s2_rdy[i] <= 1'b1;
          s2_val[i] <= cdb_data;
        end
        if (load && sel_hit && sel_oh[i]) sent[i] <= 1'b1;
        // The new entry clears its own row (younger than all); every other
        // row gains the new column, which also overwrites stale history.
        if (alloc_en && alloc_oh[i]) begin
          valid[i]  <= 1'b1;
          sent[i]   <= 1'b0;
          s1_rdy[i] <= new_s1_rdy;
          s1_val[i] <= new_s1_val;
          s1_tag[i] <= iss_s1_tag;
          s2_rdy[i] <= new_s2_rdy;
          s2_val[i] <= new_s2_val;
          s2_tag[i] <= iss_s2_tag;
          e_func[i] <= iss_func;
          e_rd[i]   <= iss_rd;
          e_rob[i]  <= iss_rob;
          age[i]    <= '0;
        end else if (alloc_en) begin
          age[i] <= age[i] | alloc_oh;
        end
      end
      if (load) begin
        exec_b <= sel_hit;
        if (sel_hit) begin
          rs_index <= sel_idx;
          rs1_data <= sel_s1;
          rs2_data <= sel_s2;
          func     <= sel_func;
          rob_ind  <= sel_rob;
          rd       <= sel_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_dispatch.sv
// Bench for rs_dispatch: directed stimulus pushes expected dispatches into a
// scoreboard; a monitor pops and compares on every accepted dispatch.
module tb_rs_dispatch;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
    logic [2:0] rob;
    logic [3:0] rd;
  } disp_t;

  logic       clk1 = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       iss_valid;
  logic       iss_ready;
  logic [3:0] iss_func;
  logic [3:0] iss_rd;
  logic [2:0] iss_rob;
  logic       iss_s1_rdy;
  logic [7:0] iss_s1_val;
  logic [3:0] iss_s1_tag;
  logic       iss_s2_rdy;
  logic [7:0] iss_s2_val;
  logic [3:0] iss_s2_tag;
  logic       cdb_valid;
  logic [3:0] cdb_tag;
  logic [7:0] cdb_data;
  logic       exec_b;
  logic       exec_ready;
  logic [2:0] rs_index;
  logic [7:0] rs1_data;
  logic [7:0] rs2_data;
  logic [3:0] func;
  logic [2:0] rob_ind;
  logic [3:0] rd;

  int    vectors = 0;
  int    miscompares = 0;
  disp_t sb[$];

  rs_dispatch #(.NUM_ENT(3), .DATA_W(8), .TAG_W(4), .ROB_W(3)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
    .iss_rd(iss_rd), .iss_rob(iss_rob),
    .iss_s1_rdy(iss_s1_rdy), .iss_s1_val(iss_s1_val), .iss_s1_tag(iss_s1_tag),
    .iss_s2_rdy(iss_s2_rdy), .iss_s2_val(iss_s2_val), .iss_s2_tag(iss_s2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .exec_b(exec_b), .exec_ready(exec_ready), .rs_index(rs_index),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .func(func),
    .rob_ind(rob_ind), .rd(rd)
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] f, input logic [3:0] rdv, input logic [2:0] rob,
                       input logic s1r, input logic [7:0] s1v, input logic [3:0] s1t,
                       input logic s2r, input logic [7:0] s2v, input logic [3:0] s2t);
    iss_valid  = 1'b1;
    iss_func   = f;
    iss_rd     = rdv;
    iss_rob    = rob;
    iss_s1_rdy = s1r;
    iss_s1_val = s1v;
    iss_s1_tag = s1t;
    iss_s2_rdy = s2r;
    iss_s2_val = s2v;
    iss_s2_tag = s2t;
    tick();
    iss_valid  = 1'b0;
  endtask

  task automatic bcast(input logic [3:0] t, input logic [7:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
    tick();
    cdb_valid = 1'b0;
  endtask

  function automatic disp_t mk(input logic [2:0] idx, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] f, input logic [2:0] rob, input logic [3:0] rdv);
    disp_t d;
    d.idx = idx; d.a = a; d.b = b; d.f = f; d.rob = rob; d.rd = rdv;
    return d;
  endfunction

  // Monitor: every accepted dispatch must match the head of the scoreboard
  initial begin
    disp_t exp_d;
    disp_t act_d;
    forever begin
      @(negedge clk1);
      if (rst_n === 1'b1 && exec_b === 1'b1 && exec_ready === 1'b1) begin
        act_d = mk(rs_index, rs1_data, rs2_data, func, rob_ind, rd);
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL dispatch_unexpected: got idx=%0d a=%0h b=%0h f=%0h rob=%0d rd=%0d expected none",
                   act_d.idx, act_d.a, act_d.b, act_d.f, act_d.rob, act_d.rd);
        end else begin
          exp_d = sb.pop_front();
          if (act_d !== exp_d) begin
            miscompares++;
            $display("FAIL dispatch: got idx=%0d a=%0h b=%0h f=%0h rob=%0d rd=%0d expected idx=%0d a=%0h b=%0h f=%0h rob=%0d rd=%0d",
                     act_d.idx, act_d.a, act_d.b, act_d.f, act_d.rob, act_d.rd,
                     exp_d.idx, exp_d.a, exp_d.b, exp_d.f, exp_d.rob, exp_d.rd);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; iss_valid = 1'b0; iss_func = '0; iss_rd = '0; iss_rob = '0;
    iss_s1_rdy = 1'b0; iss_s1_val = '0; iss_s1_tag = '0;
    iss_s2_rdy = 1'b0; iss_s2_val = '0; iss_s2_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; exec_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_exec_b", exec_b, 0);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_outputs", {rs_index, rs1_data, rs2_data, func, rob_ind, rd}, 0);
    #9 rst_n = 1'b1;
    tick();

    // T1: add, both ready
    sb.push_back(mk(3'd0, 8'h03, 8'h04, 4'h0, 3'd0, 4'd5));
    issue(4'h0, 4'd5, 3'd0, 1'b1, 8'h03, 4'd0, 1'b1, 8'h04, 4'd0);
    chk("t1_not_yet", exec_b, 0);
    tick();
    chk("t1_exec_b", exec_b, 1);
    chk("t1_rs_index", rs_index, 0);
    tick();
    chk("t1_freed_exec_b", exec_b, 0);
    chk("t1_iss_ready", iss_ready, 1);

    // T2: mul waiting on tag 5, broadcast two cycles later
    sb.push_back(mk(3'd0, 8'h07, 8'h02, 4'h2, 3'd1, 4'd9));
    issue(4'h2, 4'd9, 3'd1, 1'b0, 8'h00, 4'd5, 1'b1, 8'h02, 4'd0);
    tick();
    chk("t2_waiting", exec_b, 0);
    bcast(4'd5, 8'h07);
    chk("t2_wake_edge", exec_b, 0);
    tick();
    chk("t2_exec_b", exec_b, 1);
    chk("t2_rs1", rs1_data, 8'h07);
    tick();

    // T3: fill, overflow ignored, dispatch by age not index
    issue(4'h0, 4'd1, 3'd1, 1'b0, 8'h00, 4'd10, 1'b1, 8'hA2, 4'd0);  // A -> entry 0
    issue(4'h1, 4'd2, 3'd2, 1'b0, 8'h00, 4'd11, 1'b1, 8'hB2, 4'd0);  // B -> entry 1
    issue(4'h2, 4'd3, 3'd3, 1'b0, 8'h00, 4'd12, 1'b1, 8'hC2, 4'd0);  // C -> entry 2
    chk("t3_full", iss_ready, 0);
    issue(4'h3, 4'd4, 3'd4, 1'b1, 8'hD1, 4'd0, 1'b1, 8'hD2, 4'd0);   // D ignored
    chk("t3_still_full", iss_ready, 0);
    chk("t3_no_dispatch", exec_b, 0);
    sb.push_back(mk(3'd1, 8'h11, 8'hB2, 4'h1, 3'd2, 4'd2));
    bcast(4'd11, 8'h11);
    tick();
    tick();
    chk("t3_slot_free", iss_ready, 1);
    issue(4'h0, 4'd6, 3'd6, 1'b0, 8'h00, 4'd12, 1'b1, 8'hE2, 4'd0);  // E -> entry 1, youngest
    sb.push_back(mk(3'd2, 8'h12, 8'hC2, 4'h2, 3'd3, 4'd3));
    sb.push_back(mk(3'd1, 8'h12, 8'hE2, 4'h0, 3'd6, 4'd6));
    bcast(4'd12, 8'h12);
    tick();
    chk("t3_oldest_first", rs_index, 2);
    tick();
    chk("t3_then_younger", rs_index, 1);
    tick();
    sb.push_back(mk(3'd0, 8'h10, 8'hA2, 4'h0, 3'd1, 4'd1));
    bcast(4'd10, 8'h10);
    tick();
    tick();
    tick();
    chk("t3_drained", exec_b, 0);

    // T4: back-pressure holds outputs
    exec_ready = 1'b0;
    sb.push_back(mk(3'd0, 8'h21, 8'h22, 4'h0, 3'd2, 4'd1));
    sb.push_back(mk(3'd1, 8'h31, 8'h32, 4'h1, 3'd3, 4'd2));
    issue(4'h0, 4'd1, 3'd2, 1'b1, 8'h21, 4'd0, 1'b1, 8'h22, 4'd0);
    issue(4'h1, 4'd2, 3'd3, 1'b1, 8'h31, 4'd0, 1'b1, 8'h32, 4'd0);
    chk("t4_exec_b", exec_b, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_hold", {exec_b, rs_index, rs1_data, rs2_data, func, rob_ind, rd},
          {1'b1, 3'd0, 8'h21, 8'h22, 4'h0, 3'd2, 4'd1});
    end
    exec_ready = 1'b1;
    tick();
    chk("t4_next", {exec_b, rs_index}, {1'b1, 3'd1});
    tick();
    chk("t4_drained", exec_b, 0);

    // T5: issue bypass from same-cycle broadcast
    sb.push_back(mk(3'd0, 8'hAA, 8'h05, 4'h1, 3'd4, 4'd6));
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 8'hAA;
    issue(4'h1, 4'd6, 3'd4, 1'b0, 8'h00, 4'd3, 1'b1, 8'h05, 4'd0);
    cdb_valid = 1'b0;
    tick();
    chk("t5_exec_b", exec_b, 1);
    chk("t5_rs1", rs1_data, 8'hAA);
    tick();

    // T6: flush with pending dispatch, then async reset mid-stall
    exec_ready = 1'b0;
    issue(4'h0, 4'd3, 3'd6, 1'b1, 8'h41, 4'd0, 1'b1, 8'h42, 4'd0);
    issue(4'h1, 4'd4, 3'd7, 1'b0, 8'h00, 4'd15, 1'b1, 8'h52, 4'd0);
    chk("t6_pending", exec_b, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_exec_b", exec_b, 0);
    chk("t6_flush_ready", iss_ready, 1);
    exec_ready = 1'b1;
    tick();
    tick();
    chk("t6_flush_empty", exec_b, 0);
    exec_ready = 1'b0;
    issue(4'h3, 4'd7, 3'd5, 1'b1, 8'h33, 4'd0, 1'b1, 8'h44, 4'd0);
    tick();
    chk("t6_stalled", exec_b, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_outputs", {exec_b, rs_index, rs1_data, rs2_data, func, rob_ind, rd}, 0);
    chk("t6_rst_ready", iss_ready, 1);
    #3 rst_n = 1'b1;
    exec_ready = 1'b1;
    tick();
    tick();
    chk("t6_after_rst", exec_b, 0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
